mat_mem_arbiter: RTL

MAT_MEM_ARBITER -- requirements
Module: mat_mem_arbiter

---
 rtl/mat_mem_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/mat_mem_arbiter.sv
// Round-robin arbiter giving three matrix-unit requesters exclusive access to one
// matrix memory port, with completion pulses, shared read-data return and a sticky abort on timeout.
module mat_mem_arbiter #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic         clk,
  input  logic         RESET,
  input  logic [2:0]   reqEN,
  input  logic [2:0]   reqRW,
  input  logic [7:0]   reqAddr0,
  input  logic [7:0]   reqAddr1,
  input  logic [7:0]   reqAddr2,
  input  logic [255:0] reqData0,
  input  logic [255:0] reqData1,
  input  logic [255:0] reqData2,
  output logic [2:0]   reqFleg,
  output logic [255:0] rdData,
  output logic [1:0]   grant,
  output logic         busy,
  output logic         timeoutErr,
  output logic         memEN,
  output logic         memRW,
  output logic [7:0]   memAddr,
  output logic [255:0] toMemBus,
  input  logic [255:0] fromMemBus,
  input  logic         memFleg
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t       state;
  logic [1:0]   rrPtr;
  logic         latRW;
  logic [7:0]   latAddr;
  logic [255:0] latData;
  logic [7:0]   waitCnt;

  // candIdx[k] is the requester examined k-th, starting at rrPtr and wrapping 2->0
  logic [1:0] candIdx [3];
  for (genvar gi = 0; gi < 3; gi++) begin : g_cand
    logic [2:0] sum;
    assign sum          = {1'b0, rrPtr} + 3'(gi);
    assign candIdx[gi]  = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
  end

  logic [1:0] winIdx;
  logic       winValid;
  always_comb begin
    winIdx   = 2'd0;
    winValid = 1'b0;
    // Walk from the farthest candidate back so the nearest one to rrPtr wins
    for (int i = 2; i >= 0; i--) begin
      if (reqEN[candIdx[i]]) begin
        winIdx   = candIdx[i];
        winValid = 1'b1;
      end
    end
  end

  logic         winRW;
  logic [7:0]   winAddr;
  logic [255:0] winData;
  always_comb begin
    winRW = reqRW[winIdx];
    case (winIdx)
      2'd1:    begin winAddr = reqAddr1; winData = reqData1; end
      2'd2:    begin winAddr = reqAddr2; winData = reqData2; end
      default: begin winAddr = reqAddr0; winData = reqData0; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      state      <= IDLE;
      rrPtr      <= 2'd0;
      grant      <= 2'b11;
      busy       <= 1'b0;
      memEN      <= 1'b0;
      memRW      <= 1'b0;
      memAddr    <= 8'd0;
      toMemBus   <= '0;
      rdData     <= '0;
      reqFleg    <= 3'b000;
      timeoutErr <= 1'b0;
      waitCnt    <= 8'd0;
      latRW      <= 1'b0;
      latAddr    <= 8'd0;
      latData    <= '0;
    end else begin
      reqFleg <= 3'b000;
      case (state)
        IDLE: begin
          if (winValid) begin
            grant   <= winIdx;
            latRW   <= winRW;
            latAddr <= winAddr;
            latData <= winData;
            busy    <= 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          memEN    <= 1'b1;
          memRW    <= latRW;
          memAddr  <= latAddr;
          toMemBus <= latData;
          waitCnt  <= 8'd0;
          state    <= WAIT;
        end
        WAIT: begin
          if (memFleg) begin
            memEN   <= 1'b0;
            if (latRW) rdData <= fromMemBus;
            reqFleg <= 3'b001 << grant;
            state   <= RESP;
          end else if (waitCnt == 8'(TIMEOUT_CYC - 1)) begin
            // This WAIT cycle is the TIMEOUT_CYC-th without a response: abort
            memEN      <= 1'b0;
            timeoutErr <= 1'b1;
            reqFleg    <= 3'b001 << grant;
            state      <= RESP;
          end else begin
            waitCnt <= waitCnt + 8'd1;
          end
        end
        RESP: begin
          if (!reqEN[grant]) begin
            rrPtr <= (grant == 2'd2) ? 2'd0 : grant + 2'd1;
            grant <= 2'b11;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
